// File: rtl/multi_timer.sv
// multi_timer: bank of NUM_CH down-counting timers behind a simple word-addressed register bus,
// each with one-shot/auto-reload modes, a sticky pending flag and a maskable interrupt.
module multi_timer #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    localparam logic [WIDTH-1:0] ONE = 1;
    logic [1:0] sel;
    logic [2:0] ch;
    logic [NUM_CH-1:0][31:0] rd;
    logic [NUM_CH-1:0] irq_v;
    logic unused_bits;
    assign sel = addr[1:0];
    assign ch = addr[4:2];
    assign unused_bits = ^{addr[29:5], din};
    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        state_t state_q, state_d;
        logic [3:0] ctrl_q, ctrl_d;
        logic pend_q, pend_d;
        logic [WIDTH-1:0] preset_q, preset_d, count_q, count_d;
        logic hit;
        assign hit = we && ch == 3'(g);
        // A bus write to this channel freezes its FSM for that cycle.
        always_comb begin
            state_d = state_q;
            ctrl_d = ctrl_q;
            pend_d = pend_q;
            preset_d = preset_q;
            count_d = count_q;
            if (hit) begin
                if (sel == 2'd0) begin
                    ctrl_d = din[3:0];
                    pend_d = 1'b0;
                end else if (sel == 2'd1) begin
                    preset_d = din[WIDTH-1:0];
                end
            end else begin
                case (state_q)
                    IDLE: state_d = ctrl_q[0] ? LOAD : IDLE;
                    LOAD: begin
                        count_d = preset_q;
                        state_d = CNT;
                    end
                    CNT: begin
                        if (!ctrl_q[0]) begin
                            state_d = IDLE;
                        end else if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else begin
                            count_d = '0;
                            pend_d = 1'b1;
                            state_d = INT;
                        end
                    end
                    INT: begin
                        if (ctrl_q[2:1] == 2'b01) begin
                            state_d = LOAD;
                        end else begin
                            ctrl_d[0] = 1'b0;
                            state_d = IDLE;
                        end
                    end
                endcase
            end
        end
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                ctrl_q <= '0;
                pend_q <= 1'b0;
                preset_q <= '0;
                count_q <= '0;
            end else begin
                state_q <= state_d;
                ctrl_q <= ctrl_d;
                pend_q <= pend_d;
                preset_q <= preset_d;
                count_q <= count_d;
            end
        end
        assign rd[g] = sel == 2'd0 ? {27'b0, pend_q, ctrl_q} :
                       sel == 2'd1 ? 32'(preset_q) :
                       sel == 2'd2 ? 32'(count_q) : 32'b0;
        assign irq_v[g] = pend_q & ctrl_q[3];
    end
    always_comb begin
        dout = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == 3'(i)) dout = rd[i];
        end
    end
    assign irq = |irq_v;
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: randomized and directed bus traffic against a position-based timer model,
// checked through a scoreboard queue drained by a negedge monitor.
module tb_multi_timer;
    localparam int NC = 2;
    localparam int W = 16;
    localparam int MASK = (1 << W) - 1;
    logic clk = 1'b0;
    logic reset, we;
    logic [29:0] addr;
    logic [31:0] din, dout;
    logic irq;
    multi_timer #(.NUM_CH(NC), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .din(din), .dout(dout), .irq(irq)
    );
    always #5 clk = ~clk;
    typedef struct {int ch; int sel; logic [31:0] d; logic i;} exp_t;
    exp_t sb[$];
    int checks = 0;
    int passed = 0;
    bit smp = 0;
    bit end_chk = 0;
    // Model: pos = -1 idle, 0 loading, 1..len counting, len+1 expired; lp = preset latched at load.
    bit m_en[8], m_im[8], m_pend[8];
    int m_mode[8], m_preset[8], m_count[8], m_pos[8], m_lp[8];

    function automatic logic [31:0] exp_rd(int c, int s);
        if (c >= NC) return 32'b0;
        case (s)
            0: return {27'b0, m_pend[c], m_im[c], 2'(m_mode[c]), m_en[c]};
            1: return 32'(m_preset[c]);
            2: return 32'(m_count[c]);
            default: return 32'b0;
        endcase
    endfunction

    function automatic logic exp_irq();
        logic r = 1'b0;
        for (int c = 0; c < NC; c++) r |= m_pend[c] & m_im[c];
        return r;
    endfunction

    function automatic void step(bit r, bit w, int wc, int s, logic [31:0] d);
        for (int c = 0; c < 8; c++) begin
            int len;
            if (r) begin
                m_en[c] = 0; m_im[c] = 0; m_pend[c] = 0; m_mode[c] = 0;
                m_preset[c] = 0; m_count[c] = 0; m_pos[c] = -1; m_lp[c] = 0;
                continue;
            end
            if (c >= NC) continue;
            if (w && wc == c) begin
                if (s == 0) begin
                    m_en[c] = d[0]; m_mode[c] = int'(d[2:1]); m_im[c] = d[3]; m_pend[c] = 0;
                end else if (s == 1) begin
                    m_preset[c] = int'(d) & MASK;
                end
                continue;
            end
            len = m_lp[c] == 0 ? 1 : m_lp[c];
            if (m_pos[c] < 0) begin
                if (m_en[c]) m_pos[c] = 0;
            end else if (m_pos[c] == 0) begin
                m_lp[c] = m_preset[c];
                m_count[c] = m_preset[c];
                m_pos[c] = 1;
            end else if (m_pos[c] <= len) begin
                if (!m_en[c]) m_pos[c] = -1;
                else if (m_pos[c] == len) begin
                    m_count[c] = 0; m_pend[c] = 1; m_pos[c] = len + 1;
                end else begin
                    m_pos[c]++;
                    m_count[c] = m_lp[c] - (m_pos[c] - 1);
                end
            end else if (m_mode[c] == 1) begin
                m_pos[c] = 0;
            end else begin
                m_en[c] = 0; m_pos[c] = -1;
            end
        end
    endfunction

    task automatic op(input bit r, input bit w, input int c, input int s, input logic [31:0] d);
        reset = r; we = w; din = d;
        addr = {25'b0, 3'(c), 2'(s)};
        sb.push_back('{c, s, exp_rd(c, s), exp_irq()});
        smp = 1;
        @(posedge clk);
        step(r, w, c, s, d);
        #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (smp) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL scoreboard underflow got 0 entries exp >=1");
            end else begin
                e = sb.pop_front();
                checks++;
                if (dout === e.d) passed++;
                else $display("FAIL dout ch=%0d sel=%0d got %h exp %h", e.ch, e.sel, dout, e.d);
                checks++;
                if (irq === e.i) passed++;
                else $display("FAIL irq ch=%0d sel=%0d got %b exp %b", e.ch, e.sel, irq, e.i);
            end
        end
        if (end_chk) begin
            checks++;
            if (sb.size() == 0) passed++;
            else $display("FAIL scoreboard leftover got %0d exp 0", sb.size());
        end
    end

    initial begin
        reset = 1; we = 0; addr = '0; din = '0;
        step(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) op(0, 0, 0, s, 0);
        op(0, 0, 1, 0, 0);
        // one-shot
        op(0, 1, 0, 1, 5);
        op(0, 1, 0, 0, 32'h9);
        repeat (10) op(0, 0, 0, 2, 0);
        op(0, 0, 0, 0, 0);
        op(0, 1, 0, 0, 0);
        // auto-reload with pend clear
        op(0, 1, 1, 1, 3);
        op(0, 1, 1, 0, 32'hB);
        repeat (12) op(0, 0, 1, 2, 0);
        op(0, 1, 1, 0, 32'hB);
        repeat (8) op(0, 0, 1, 0, 0);
        op(0, 1, 1, 0, 0);
        // masked expiry
        op(0, 1, 0, 1, 2);
        op(0, 1, 0, 0, 32'h1);
        repeat (6) op(0, 0, 0, 0, 0);
        op(0, 1, 0, 0, 32'h8);
        repeat (2) op(0, 0, 0, 0, 0);
        // disable mid-count
        op(0, 1, 0, 1, 10);
        op(0, 1, 0, 0, 32'h1);
        repeat (6) op(0, 0, 0, 2, 0);
        op(0, 1, 0, 0, 0);
        repeat (4) op(0, 0, 0, 2, 0);
        op(0, 0, 0, 0, 0);
        // collision between bus write and counting
        op(0, 1, 0, 1, 20);
        op(0, 1, 1, 1, 20);
        op(0, 1, 0, 0, 32'h1);
        op(0, 1, 1, 0, 32'h1);
        repeat (4) op(0, 0, 0, 2, 0);
        op(0, 1, 0, 1, 7);
        op(0, 0, 0, 2, 0);
        op(0, 0, 1, 2, 0);
        // reset while counting with a pending channel
        op(0, 1, 1, 1, 1);
        op(0, 1, 1, 0, 32'hB);
        repeat (5) op(0, 0, 1, 0, 0);
        op(0, 0, 0, 2, 0);
        op(1, 1, 0, 1, 99);
        for (int c = 0; c < 2; c++) for (int s = 0; s < 4; s++) op(0, 0, c, s, 0);
        op(0, 1, 5, 1, 123);
        op(0, 0, 5, 1, 0);
        op(0, 1, 5, 0, 32'hF);
        op(0, 0, 5, 0, 0);
        // random traffic, truncation of wide preset writes included
        repeat (3000) begin
            int c, s;
            bit w, r;
            logic [31:0] d;
            c = ($urandom % 4 < 3) ? int'($urandom % 2) : int'($urandom % 8);
            s = int'($urandom % 4);
            w = ($urandom % 5) == 0;
            r = ($urandom % 100) == 0;
            d = (s == 1) ? {($urandom % 2) ? 16'($urandom) : 16'h0, 16'($urandom % 12)} : $urandom;
            op(r, w, c, s, d);
        end
        smp = 0;
        end_chk = 1;
        @(negedge clk);
        #1;
        end_chk = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent timer channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 32, bit width of each channel's PRESET and COUNT (8..32).
REQ-003 SHALL have port clk input 1, rising-edge clock.
REQ-004 SHALL have port reset input 1, synchronous, active-high.
REQ-005 SHALL have port addr input 30, word address bits [31:2]. Bits [3:2] select the register; bits [6:4] select the channel.
REQ-006 SHALL have port we input 1, bus write strobe.
REQ-007 SHALL have port din input 32, write data.
REQ-008 SHALL have port dout output 32, combinational read data.
REQ-009 SHALL have port irq output 1, OR of all channel interrupt requests.

Function
REQ-010 SHALL provide per-channel registers: CTRL (sel 0), PRESET (sel 1), COUNT (sel 2, read-only), sel 3 reserved (reads 0).
REQ-011 SHALL define CTRL[0] as EN (enable) and CTRL[2:1] as MODE: 00 one-shot, 01 auto-reload, 1x treated as 00.
REQ-012 SHALL define CTRL[3] as IM (interrupt mask, 1 = enabled) and CTRL[4] as PEND (read-only pending flag). CTRL[31:5] SHALL read 0.
REQ-013 SHALL, on a CTRL write, store din[3:0] and clear PEND.
REQ-014 SHALL, on a PRESET write, store din[WIDTH-1:0].
REQ-015 SHALL ignore writes to COUNT, to sel 3, and to channel index >= NUM_CH.
REQ-016 SHALL zero-extend PRESET and COUNT reads to 32 bits.
REQ-017 SHALL return 0 on dout for channel index >= NUM_CH.
REQ-018 SHALL run one 4-state FSM per channel: IDLE, LOAD, CNT, INT.
REQ-019 SHALL take IDLE -> LOAD when EN=1.
REQ-020 SHALL, in LOAD, set COUNT <= PRESET and go to CNT.
REQ-021 SHALL, in CNT:
- EN=0: go to IDLE, COUNT held.
- COUNT > 1: decrement COUNT by 1.
- COUNT <= 1: set COUNT <= 0, PEND <= 1, go to INT.
REQ-022 SHALL, in INT:
- one-shot: clear EN, go to IDLE.
- auto-reload: go to LOAD, PEND stays set.
REQ-023 SHALL keep PEND sticky until a CTRL write or reset.
REQ-024 SHALL drive irq = OR over channels of (PEND & IM), combinationally from registered state.
REQ-025 SHALL, when a bus write targets a channel, suppress that channel's FSM/COUNT update for that cycle. Other channels SHALL step normally.
REQ-026 SHALL, with PRESET=0, pass LOAD -> CNT -> INT, setting PEND two cycles after LOAD.
REQ-027 SHALL give a period of PRESET+2 cycles from LOAD entry to the next LOAD entry in auto-reload (PRESET >= 1).
REQ-028 SHALL never wrap COUNT below 0.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, set all channel states to IDLE and clear all CTRL, PRESET, COUNT and PEND.
REQ-030 SHALL reset with priority over any simultaneous write or FSM step, including mid-count.
REQ-031 SHALL read dout = 0 and drive irq = 0 after reset.

Verification
REQ-032 One-shot: ch0 PRESET=5, then CTRL=0x9 -> COUNT reads 5,4,3,2,1,0 on successive cycles after LOAD; PEND=1; irq=1; CTRL[0] reads 0; COUNT stays 0.
REQ-033 Auto-reload: ch1 PRESET=3, CTRL=0xB -> COUNT reloads to 3 every 5 cycles; irq stays 1 until CTRL written with 0xB, then irq=0 until the next expiry.
REQ-034 Mask: ch0 PRESET=2, CTRL=0x1 -> CTRL reads 0x10 after expiry, irq=0; writing CTRL=0x8 -> PEND cleared, irq=0.
REQ-035 Disable mid-count: PRESET=10, EN=1; write CTRL=0 when COUNT=6 -> state IDLE, COUNT holds 6, no PEND.
REQ-036 Collision: ch0 and ch1 counting; write ch0 PRESET in a cycle -> ch0 COUNT unchanged that cycle, ch1 decrements.
REQ-037 Reset mid-operation: assert reset while ch0 COUNT=4 and PEND set on ch1 -> all registers read 0 and irq=0 next cycle. Writes to channel 5 with NUM_CH=2 have no effect and read 0.
